backing_mem: RTL and testbench
==============================

BACKING_MEM -- requirements
Module: backing_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the array, word index addr[11:2].
REQ-002 SHALL have parameter LATENCY, default 4, meaning cycles from accepted request to ready; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port mem_req_addr  input  32  byte address of request.
REQ-006 SHALL have port mem_wr_data  input  32  write data.
REQ-007 SHALL have port mem_req_vaild  input  1  request valid, held high by initiator until ready seen.
REQ-008 SHALL have port mem_req_wr  input  1  1=write, 0=read.
REQ-009 SHALL have port mem_req_data  output  32  read data, meaningful only while mem_req_ready=1.
REQ-010 SHALL have port mem_req_ready  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESP, DRAIN.
REQ-012 SHALL, in IDLE with vaild=1, latch addr/wr/wr_data, load counter with LATENCY-1, and go BUSY (or go RESP directly when LATENCY=1).
REQ-013 SHALL, in BUSY, decrement the counter each cycle and go RESP when it reaches 0, so ready rises exactly LATENCY cycles after the accepting edge.
REQ-014 SHALL ignore all input changes after acceptance until the next IDLE.
REQ-015 SHALL, in RESP, assert mem_req_ready=1 for exactly one cycle, drive the latched-word read value on mem_req_data for reads, and commit the write to the array at the RESP-ending edge for writes.
REQ-016 SHALL drive mem_req_data with the pre-write word during a write's RESP cycle.
REQ-017 SHALL hold mem_req_data at its last value outside RESP.
REQ-018 SHALL go RESP->DRAIN and stay in DRAIN while vaild=1, and go DRAIN->IDLE when vaild=0, so a stale vaild never starts a second transaction.
REQ-019 SHALL return newly written data when a read follows a write to the same word.
REQ-020 SHALL alias addresses: use only addr[11:2], ignore addr[1:0] and addr[31:12] (unless REQ-025 applies).
REQ-021 SHALL never assert mem_req_ready outside RESP.

Reset
REQ-022 SHALL, on rst=1 at any time, immediately force state=IDLE, counter=0, mem_req_ready=0, mem_req_data=0.
REQ-023 SHALL, on reset mid-transaction (BUSY or RESP), commit no write; array contents are not cleared by reset.
REQ-024 SHALL initialize the array to all zeros at simulation start.

Configuration
REQ-025 SHALL, with MEM_RANGE_CHECK_EN defined, add output mem_req_err (1 bit, reset 0), pulsed with ready when addr[31:12]!=0; on such a request a write is suppressed and read data is 0.
REQ-026 SHALL, without MEM_RANGE_CHECK_EN, have no mem_req_err port and alias all addresses per REQ-020.

Structure
REQ-027 SHALL take FSM state encodings and the default LATENCY/DEPTH constants from a shared header, next to the cache's stage header.
REQ-028 SHALL place the storage in sub-module backing_mem_array: single-port, synchronous write, combinational read, 32-bit wide.

Verification
REQ-029 SHALL cover: write 0xDEADBEEF @0x0000_0010, LATENCY=4 -> ready exactly 4 cycles after accept; subsequent read @0x10 -> data 0xDEADBEEF.
REQ-030 SHALL cover: read @0x0000_0024 after reset -> data 0x0000_0000, ready one cycle only.
REQ-031 SHALL cover: vaild held high 3 cycles after ready -> no second ready until vaild drops and is re-asserted.
REQ-032 SHALL cover: rst pulsed during BUSY of write 0x12345678 @0x40 -> ready never asserted; later read @0x40 returns prior value.
REQ-033 SHALL cover: LATENCY=1, back-to-back write/read @0x7FC -> each ready 1 cycle after accept; read returns written word.
REQ-034 SHALL cover: with MEM_RANGE_CHECK_EN, write @0x0000_1010 -> mem_req_err=1 with ready; read @0x10 unchanged. Without it, same write aliases onto word 0x10.

Source files
------------

// File: rtl/backing_mem_pkg.sv
// Shared constants, FSM state encoding and request payload for the backing memory model.
package backing_mem_pkg;

  localparam int unsigned DATA_W              = 32;
  localparam int unsigned ADDR_W              = 32;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DEFAULT_LATENCY     = 4;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Request fields captured at acceptance and held until the next IDLE
  typedef struct packed {
    logic              wr;
    logic              oor;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/backing_mem_array.sv
// Single-port word storage: synchronous write, combinational read, zero at simulation start.
module backing_mem_array
  import backing_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/backing_mem.sv
// Fixed-latency backing memory with a one-cycle ready pulse and stale-valid drain.
// Optional feature: define MEM_RANGE_CHECK_EN to add mem_req_err for addresses above 4 KiB.
module backing_mem
  import backing_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_req_vaild,
  input  logic              mem_req_wr,
  output logic [DATA_W-1:0] mem_req_data,
`ifdef MEM_RANGE_CHECK_EN
  output logic              mem_req_err,
`endif
  output logic              mem_req_ready
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] data_d;
  logic              ready_d;
  logic [DATA_W-1:0] rdata_c;
  logic              we_c;
  logic              oor_in_c;
  logic              unused_addr;
`ifdef MEM_RANGE_CHECK_EN
  logic              err_d;
`endif

  // Byte-lane and (by default) upper address bits are deliberately aliased away
  assign unused_addr = ^mem_req_addr;

`ifdef MEM_RANGE_CHECK_EN
  assign oor_in_c = (mem_req_addr[ADDR_W-1:12] != '0);
`else
  assign oor_in_c = 1'b0;
`endif

  // Write lands on the edge that ends RESP; reset drops state first, so no commit
  assign we_c = (state_q == ST_RESP) && req_q.wr && !req_q.oor;

  backing_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (we_c),
    .idx   (idx_d),
    .wdata (req_q.wdata),
    .rdata (rdata_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    req_d   = req_q;
    data_d  = mem_req_data;
    ready_d = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_vaild) begin
          idx_d       = mem_req_addr[IDX_W+1:2];
          req_d.wr    = mem_req_wr;
          req_d.oor   = oor_in_c;
          req_d.wdata = mem_wr_data;
          cnt_d       = CNT_LOAD;
          state_d     = (LATENCY <= 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_DRAIN;
      ST_DRAIN: if (!mem_req_vaild) state_d = ST_IDLE;
    endcase

    // Response outputs are loaded on entry to RESP, before any write commits
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      ready_d = 1'b1;
      data_d  = req_d.oor ? '0 : rdata_c;
`ifdef MEM_RANGE_CHECK_EN
      err_d   = req_d.oor;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      req_q         <= '0;
      mem_req_data  <= '0;
      mem_req_ready <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      mem_req_err   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      req_q         <= req_d;
      mem_req_data  <= data_d;
      mem_req_ready <= ready_d;
`ifdef MEM_RANGE_CHECK_EN
      mem_req_err   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_backing_mem.sv
// Randomized bench for backing_mem: LATENCY=4 and LATENCY=1 instances share stimulus against a word-array model.
module tb_backing_mem;

  localparam int unsigned LAT_A = 4;
  localparam int unsigned LAT_B = 1;
  localparam int unsigned WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_wr_data;
  logic        mem_req_vaild;
  logic        mem_req_wr;
  logic [31:0] data_a, data_b;
  logic        ready_a, ready_b;
`ifdef MEM_RANGE_CHECK_EN
  logic        err_a, err_b;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [WORDS];
  logic [31:0] last_rsp;

  always #5 clk = ~clk;

  backing_mem #(.DEPTH_WORDS(WORDS), .LATENCY(LAT_A)) u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .mem_req_addr  (mem_req_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_req_vaild (mem_req_vaild),
    .mem_req_wr    (mem_req_wr),
    .mem_req_data  (data_a),
`ifdef MEM_RANGE_CHECK_EN
    .mem_req_err   (err_a),
`endif
    .mem_req_ready (ready_a)
  );

  backing_mem #(.DEPTH_WORDS(WORDS), .LATENCY(LAT_B)) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .mem_req_addr  (mem_req_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_req_vaild (mem_req_vaild),
    .mem_req_wr    (mem_req_wr),
    .mem_req_data  (data_b),
`ifdef MEM_RANGE_CHECK_EN
    .mem_req_err   (err_b),
`endif
    .mem_req_ready (ready_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_oor(input logic [31:0] a);
`ifdef MEM_RANGE_CHECK_EN
    return a >= 32'h0000_1000;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  // One full transaction: drive, check the ready window, hold valid, drop it, update model
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold);
    logic [31:0] exp_rsp;
    logic        exp_err;
    exp_err = ref_oor(addr);
    exp_rsp = exp_err ? 32'h0 : ref_mem[ref_idx(addr)];
    mem_req_vaild = 1'b1;
    mem_req_wr    = wr;
    mem_req_addr  = addr;
    mem_wr_data   = wdata;
    for (int n = 1; n <= int'(LAT_A); n++) begin
      @(negedge clk);
      mem_req_addr = $urandom;
      mem_req_wr   = 1'($urandom);
      mem_wr_data  = $urandom;
      check_eq("ready_a", 32'(ready_a), 32'(n == int'(LAT_A)));
      check_eq("ready_b", 32'(ready_b), 32'(n == int'(LAT_B)));
      check_eq("data_a", data_a, (n == int'(LAT_A)) ? exp_rsp : last_rsp);
      check_eq("data_b", data_b, (n >= int'(LAT_B)) ? exp_rsp : last_rsp);
`ifdef MEM_RANGE_CHECK_EN
      check_eq("err_a", 32'(err_a), 32'((n == int'(LAT_A)) && exp_err));
      check_eq("err_b", 32'(err_b), 32'((n == int'(LAT_B)) && exp_err));
`endif
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_ready_a", 32'(ready_a), 32'h0);
      check_eq("hold_ready_b", 32'(ready_b), 32'h0);
      check_eq("hold_data_a", data_a, exp_rsp);
      check_eq("hold_data_b", data_b, exp_rsp);
    end
    mem_req_vaild = 1'b0;
    mem_req_wr    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("drain_ready_a", 32'(ready_a), 32'h0);
      check_eq("drain_ready_b", 32'(ready_b), 32'h0);
    end
    if (wr && !exp_err) ref_mem[ref_idx(addr)] = wdata;
    last_rsp = exp_rsp;
  endtask

  // Write accepted, then reset lands before either instance can commit it
  task automatic run_abort(input logic [31:0] addr, input logic [31:0] wdata);
    mem_req_vaild = 1'b1;
    mem_req_wr    = 1'b1;
    mem_req_addr  = addr;
    mem_wr_data   = wdata;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_a", 32'(ready_a), 32'h0);
    check_eq("abort_ready_b", 32'(ready_b), 32'h0);
    check_eq("abort_data_a", data_a, 32'h0);
    check_eq("abort_data_b", data_b, 32'h0);
    mem_req_vaild = 1'b0;
    mem_req_wr    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_abort_ready_a", 32'(ready_a), 32'h0);
    check_eq("post_abort_ready_b", 32'(ready_b), 32'h0);
    last_rsp = 32'h0;
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    rst           = 1'b1;
    mem_req_vaild = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = 32'h0;
    mem_wr_data   = 32'h0;
    last_rsp      = 32'h0;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = 32'h0;

    repeat (2) @(negedge clk);
    check_eq("rst_ready_a", 32'(ready_a), 32'h0);
    check_eq("rst_ready_b", 32'(ready_b), 32'h0);
    check_eq("rst_data_a", data_a, 32'h0);
    check_eq("rst_data_b", data_b, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0024, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0024, 32'h0, 3);
    run_txn(1'b1, 32'h0000_0040, 32'hA5A5_0040, 1);
    run_abort(32'h0000_0040, 32'h1234_5678);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 0);
    run_txn(1'b1, 32'h0000_07FC, 32'hCAFE_F00D, 0);
    run_txn(1'b0, 32'h0000_07FC, 32'h0, 0);
    run_txn(1'b1, 32'h0000_1010, 32'h0BAD_1010, 0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 2);
    run_txn(1'b0, 32'h0000_0013, 32'h0, 0);

    for (int t = 0; t < 80; t++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[31:12] = 20'h0;
      if ($urandom_range(1) != 0) a[11:2] = 10'($urandom_range(15));
      w = 1'($urandom);
      run_txn(w, a, $urandom, int'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
